// File: rtl/sfir_pkg.sv
// Shared types and helpers for the symmetric systolic FIR controller.
//   sfir_ctrl_state_e    : controller state (INIT, RUN, FLUSH)
//   sfir_default_latency : default sample-to-output latency for a given element count
package sfir_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } sfir_ctrl_state_e;

   // Chain latency: two register stages per element plus input/pre-add/mult/output stages.
   function automatic int unsigned sfir_default_latency(input int unsigned num_taps);
      return 2 * num_taps + 4;
   endfunction

endpackage

// File: rtl/sfir_valid_delay.sv
// LATENCY-deep valid marker shift register with synchronous clear.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear of every stage
//   din_i  : marker entering stage 0
//   dout_o : marker leaving the last stage (registered)
module sfir_valid_delay #(
   parameter int unsigned DEPTH = 20
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic din_i,
   output logic dout_o
);

   logic [DEPTH-1:0] sr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= {sr_q[DEPTH-2:0], din_i};
      end
   end

   assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sfir_coeff_ctrl.sv
// Sequencing controller for the even-symmetric systolic FIR chain.
// Loads coefficient sets into a shadow bank, commits them atomically to the
// active bank and registers samples into the chain. With SFIR_CTRL_FLUSH_EN
// defined, each commit zero-flushes the chain for LATENCY cycles and kills
// in-flight valid markers so no output mixes two coefficient sets.
//   clk_i, rst_i                            : clock, synchronous active-high reset
//   coef_tdata_i/tvalid_i/tlast_i/tready_o  : coefficient word stream
//   s_tdata_i/s_tvalid_i/s_tready_o         : sample stream
//   coeff_o     : active bank, element k at [k*COEF_WIDTH +: COEF_WIDTH]
//   fir_data_o  : registered sample into the chain
//   out_valid_o : chain output valid this cycle
//   busy_o      : controller not in RUN
//   err_o       : sticky framing error
module sfir_coeff_ctrl
   import sfir_pkg::*;
#(
   parameter int unsigned NUM_TAPS   = 8,
   parameter int unsigned COEF_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LATENCY    = sfir_default_latency(NUM_TAPS)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [COEF_WIDTH-1:0]          coef_tdata_i,
   input  logic                           coef_tvalid_i,
   input  logic                           coef_tlast_i,
   output logic                           coef_tready_o,
   input  logic [DATA_WIDTH-1:0]          s_tdata_i,
   input  logic                           s_tvalid_i,
   output logic                           s_tready_o,
   output logic [NUM_TAPS*COEF_WIDTH-1:0] coeff_o,
   output logic [DATA_WIDTH-1:0]          fir_data_o,
   output logic                           out_valid_o,
   output logic                           busy_o,
   output logic                           err_o
);

   localparam int unsigned      IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TAPS - 1);

   sfir_ctrl_state_e      state_q;
   logic [COEF_WIDTH-1:0] shadow_q [NUM_TAPS];
   logic [IDX_W-1:0]      idx_q;
   logic                  vmark_q;
   logic                  coef_acc;
   logic                  s_acc;
   logic                  commit;
   logic                  frame_err;
   logic                  vd_clr;

`ifdef SFIR_CTRL_FLUSH_EN
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   logic [CNT_W-1:0] flush_cnt_q;
   assign vd_clr = commit;
`else
   assign vd_clr = 1'b0;
`endif

   // Handshakes are qualified with the registered ready outputs the sources see.
   assign coef_acc  = coef_tvalid_i & coef_tready_o;
   assign s_acc     = s_tvalid_i & s_tready_o;
   assign commit    = coef_acc & coef_tlast_i & (idx_q == IDX_LAST);
   assign frame_err = coef_acc & (coef_tlast_i != (idx_q == IDX_LAST));

   // Shadow/active banks, word index and sticky framing error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < int'(NUM_TAPS); k++) shadow_q[k] <= '0;
         coeff_o <= '0;
         idx_q   <= '0;
         err_o   <= 1'b0;
      end else if (coef_acc) begin
         shadow_q[idx_q] <= coef_tdata_i;
         if (commit) begin
            // Last word bypasses the shadow so the whole set lands in one edge.
            for (int k = 0; k < int'(NUM_TAPS) - 1; k++)
               coeff_o[k*COEF_WIDTH +: COEF_WIDTH] <= shadow_q[k];
            coeff_o[(NUM_TAPS-1)*COEF_WIDTH +: COEF_WIDTH] <= coef_tdata_i;
            idx_q <= '0;
         end else if (frame_err) begin
            err_o <= 1'b1;
            idx_q <= '0;
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   // Controller FSM with registered handshake/status outputs and sample register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_INIT;
         coef_tready_o <= 1'b0;
         s_tready_o    <= 1'b0;
         busy_o        <= 1'b1;
         fir_data_o    <= '0;
         vmark_q       <= 1'b0;
`ifdef SFIR_CTRL_FLUSH_EN
         flush_cnt_q   <= '0;
`endif
      end else begin
         fir_data_o    <= '0;
         vmark_q       <= 1'b0;
         coef_tready_o <= 1'b1;
         unique case (state_q)
            ST_INIT: begin
               if (commit) begin
`ifdef SFIR_CTRL_FLUSH_EN
                  state_q       <= ST_FLUSH;
                  coef_tready_o <= 1'b0;
                  flush_cnt_q   <= '0;
`else
                  state_q    <= ST_RUN;
                  s_tready_o <= 1'b1;
                  busy_o     <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               // No stall in the chain: an idle cycle inserts a zero sample.
               fir_data_o <= s_acc ? s_tdata_i : '0;
               vmark_q    <= s_acc;
`ifdef SFIR_CTRL_FLUSH_EN
               if (commit) begin
                  // Sample of the commit cycle still enters; its marker is dropped.
                  state_q       <= ST_FLUSH;
                  s_tready_o    <= 1'b0;
                  busy_o        <= 1'b1;
                  coef_tready_o <= 1'b0;
                  flush_cnt_q   <= '0;
                  vmark_q       <= 1'b0;
               end
`endif
            end
`ifdef SFIR_CTRL_FLUSH_EN
            ST_FLUSH: begin
               if (flush_cnt_q == CNT_W'(LATENCY - 1)) begin
                  state_q    <= ST_RUN;
                  s_tready_o <= 1'b1;
                  busy_o     <= 1'b0;
               end else begin
                  coef_tready_o <= 1'b0;
                  flush_cnt_q   <= flush_cnt_q + CNT_W'(1);
               end
            end
`endif
            default: state_q <= ST_INIT;
         endcase
      end
   end

   sfir_valid_delay #(
      .DEPTH (LATENCY)
   ) u_valid_delay (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (vd_clr),
      .din_i  (vmark_q),
      .dout_o (out_valid_o)
   );

endmodule
